// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder: two half adders plus a carry flip-flop process one
// operand bit per clock. Parallel load, parallel result, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0]    cnt;
  logic             c_q, c_nxt;
  logic             ha0_sum, ha0_carry, ha1_sum, ha1_carry;
  logic             last;

  half_adder ha0 (.a(a_sh[0]), .b(b_sh[0]), .sum(ha0_sum), .carry(ha0_carry));
  half_adder ha1 (.a(ha0_sum), .b(c_q),     .sum(ha1_sum), .carry(ha1_carry));

  assign last = (state == RUN) && (cnt == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Full-adder combine and result shift; MSB insert written this way so WIDTH=1 works
  always_comb begin
    c_nxt            = ha0_carry | ha1_carry;
    r_nxt            = r_sh >> 1;
    r_nxt[WIDTH-1]   = ha1_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start only honoured in IDLE, DONE always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shifting, result latch on the final RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= in_a;
            b_sh <= in_b;
            r_sh <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          c_q  <= c_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            sum   <= r_nxt;
            carry <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q here is still the carry into the MSB
            ovf   <= c_q ^ c_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 main instance, WIDTH=1 side instance).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_a, in_b;
  logic       busy, done, carry;
  logic [7:0] sum;
  logic       ovf;

  logic       start1;
  logic [0:0] in_a1, in_b1, sum1;
  logic       busy1, done1, carry1;
  logic       ovf1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_a(in_a1), .in_b(in_b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition and the two's-complement overflow rule
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    s = int'(a) + int'(b);
    return s[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    return (s > 127) || (s < -128);
  endfunction

  // Waits for done after an accept edge; returns number of edges taken
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] e;
    e = ref_add(a, b);
    chk({tag, "_sum"},   32'(sum),   32'(e[7:0]));
    chk({tag, "_carry"}, 32'(carry), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},   32'(ovf),   32'(ref_ovf(a, b)));
`endif
  endtask

  // One complete transaction: start pulse, latency check, result, single-cycle done
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b);
    int n;
    start = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    start = 1'b0; in_a = $urandom; in_b = $urandom;
    wait_done(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_done"}, 32'(done), 32'd1);
    check_result(tag, a, b);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; in_a = '0; in_b = '0;
    start1 = 1'b0; in_a1 = '0; in_b1 = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and full-range cases
    do_add("basic", 8'h0F, 8'h01);
    do_add("ff_01", 8'hFF, 8'h01);
    do_add("ff_ff", 8'hFF, 8'hFF);
    do_add("zero", 8'h00, 8'h00);
    do_add("ovf_7f", 8'h7F, 8'h01);
    do_add("ovf_80", 8'h80, 8'h80);

    // Start ignored during RUN and DONE
    start = 1'b1; in_a = 8'h12; in_b = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", n);
    chk("ign_latency", 32'(n), 32'd5);
    check_result("ign", 8'h12, 8'h34);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done_off", 32'(done), 32'd0);
    chk("ign_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("ign_still_idle", 32'(busy), 32'd0);
    chk("ign_hold_sum", 32'(sum), 32'h46);
    do_add("after_ign", 8'hFF, 8'hFF);

    // Reset mid-operation
    start = 1'b1; in_a = 8'hAA; in_b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_carry", 32'(carry), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("mid_rst_no_done", 32'(n), 32'd0);
    do_add("post_rst", 8'h01, 8'h02);

    // Back-to-back with start held high
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      in_a = ra; in_b = rb;
      @(posedge clk); #1;
      chk("b2b_accept", 32'(busy), 32'd1);
      in_a = 8'($urandom); in_b = 8'($urandom);
      wait_done("b2b", n);
      chk("b2b_latency", 32'(n), 32'd8);
      check_result("b2b", ra, rb);
      @(posedge clk); #1;
      chk("b2b_gap", 32'(busy | done), 32'd0);
    end
    start = 1'b0;
    @(posedge clk); #1;

    // Random single transactions
    for (int i = 0; i < 20; i++) begin
      do_add("rand", 8'($urandom), 8'($urandom));
    end

    // WIDTH=1 instance: all four operand pairs
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      start1 = 1'b1; in_a1 = ab[0]; in_b1 = ab[1];
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      @(posedge clk); #1;
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_sum", 32'(sum1), 32'(ab[0] ^ ab[1]));
      chk("w1_carry", 32'(carry1), 32'(ab[0] & ab[1]));
      @(posedge clk); #1;
      chk("w1_done_off", 32'(done1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
